// File: rtl/axi4_burst_traffic_gen.sv
`default_nettype none
// ============================================================================
// axi4_burst_traffic_gen - AXI4 master issuing CFG_NUM_BURST+1 INCR bursts in
// write, read or write-then-readback-compare mode. Rev 1.0
// ============================================================================
module axi4_burst_traffic_gen #(
    parameter int MP_AXI_ID_WIDTH   = 1,
    parameter int MP_AXI_ADDR_WIDTH = 32,
    parameter int MP_AXI_DATA_WIDTH = 32,
    parameter int MP_NB_WIDTH       = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           INIT_AXI_TXN,
    input  logic [MP_AXI_ADDR_WIDTH-1:0]   CFG_BASE_WADDR,
    input  logic [MP_AXI_ADDR_WIDTH-1:0]   CFG_BASE_RADDR,
    input  logic [MP_NB_WIDTH-1:0]         CFG_NUM_BURST,
    input  logic [8:0]                     CFG_BURST_LEN,
    input  logic [1:0]                     CFG_MODE,
    output logic                           AXI_TXN_DONE,
    output logic                           AXI_ERROR,
    output logic [MP_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [MP_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                     M_AXI_AWLEN,
    output logic [2:0]                     M_AXI_AWSIZE,
    output logic [1:0]                     M_AXI_AWBURST,
    output logic                           M_AXI_AWVALID,
    input  logic                           M_AXI_AWREADY,
    output logic [MP_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [MP_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                           M_AXI_WLAST,
    output logic                           M_AXI_WVALID,
    input  logic                           M_AXI_WREADY,
    input  logic [1:0]                     M_AXI_BRESP,
    input  logic                           M_AXI_BVALID,
    output logic                           M_AXI_BREADY,
    output logic [MP_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [MP_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                     M_AXI_ARLEN,
    output logic [2:0]                     M_AXI_ARSIZE,
    output logic [1:0]                     M_AXI_ARBURST,
    output logic                           M_AXI_ARVALID,
    input  logic                           M_AXI_ARREADY,
    input  logic [MP_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                     M_AXI_RRESP,
    input  logic                           M_AXI_RLAST,
    input  logic                           M_AXI_RVALID,
    output logic                           M_AXI_RREADY
);

    localparam int         AW   = MP_AXI_ADDR_WIDTH;
    localparam int         DW   = MP_AXI_DATA_WIDTH;
    localparam int         NB   = MP_NB_WIDTH;
    localparam int         PW   = NB + 10;
    localparam logic [2:0] SIZE = 3'($clog2(DW / 8));

    typedef enum logic [2:0] {
        IDLE, CHECK, WADDR, WDATA, WRESP, RADDR, RDATA, DONE
    } state_t;

    state_t        state;
    logic          init_q;
    logic [8:0]    cfg_len;
    logic [NB-1:0] cfg_nb;
    logic [1:0]    cfg_mode;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [NB-1:0] burst_cnt;
    logic [8:0]    beat_cnt;
    logic [PW-1:0] wpat;
    logic [PW-1:0] rpat;
    logic [12:0]   burst_bytes;
    logic [11:0]   woff;
    logic [11:0]   roff;
    logic          wcross;
    logic          rcross;
    logic          len_bad;
    logic          check_fail;
    logic          last_beat;
    logic          start;

    assign M_AXI_AWID  = '0;
    assign M_AXI_ARID  = '0;
    assign burst_bytes = 13'(cfg_len) << SIZE;
    assign len_bad     = (cfg_len == 9'd0) || (cfg_len > 9'd256);
    assign last_beat   = (beat_cnt == cfg_len - 9'd1);
    assign start       = INIT_AXI_TXN && !init_q && (state == IDLE || state == DONE);

    // Walk every burst's page offset so a crossing anywhere in the run is caught in CHECK.
    always_comb begin
        wcross = 1'b0;
        rcross = 1'b0;
        woff   = waddr[11:0];
        roff   = raddr[11:0];
        for (int n = 0; n < (1 << NB); n++) begin
            if (NB'(n) <= cfg_nb) begin
                if ({1'b0, woff} + burst_bytes > 13'd4096) wcross = 1'b1;
                if ({1'b0, roff} + burst_bytes > 13'd4096) rcross = 1'b1;
            end
            woff = woff + burst_bytes[11:0];
            roff = roff + burst_bytes[11:0];
        end
    end

    assign check_fail = len_bad || (cfg_mode == 2'b11)
                     || ((cfg_mode != 2'b01) && wcross)
                     || ((cfg_mode != 2'b00) && rcross);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            init_q        <= 1'b0;
            cfg_len       <= '0;
            cfg_nb        <= '0;
            cfg_mode      <= '0;
            waddr         <= '0;
            raddr         <= '0;
            burst_cnt     <= '0;
            beat_cnt      <= '0;
            wpat          <= '0;
            rpat          <= '0;
            AXI_TXN_DONE  <= 1'b0;
            AXI_ERROR     <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWLEN   <= '0;
            M_AXI_AWSIZE  <= '0;
            M_AXI_AWBURST <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WLAST   <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
            M_AXI_ARSIZE  <= '0;
            M_AXI_ARBURST <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            init_q <= INIT_AXI_TXN;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cfg_len       <= CFG_BURST_LEN;
                        cfg_nb        <= CFG_NUM_BURST;
                        cfg_mode      <= CFG_MODE;
                        waddr         <= CFG_BASE_WADDR;
                        raddr         <= CFG_BASE_RADDR;
                        M_AXI_AWLEN   <= 8'(CFG_BURST_LEN - 9'd1);
                        M_AXI_ARLEN   <= 8'(CFG_BURST_LEN - 9'd1);
                        M_AXI_AWSIZE  <= SIZE;
                        M_AXI_ARSIZE  <= SIZE;
                        M_AXI_AWBURST <= 2'b01;
                        M_AXI_ARBURST <= 2'b01;
                        M_AXI_WSTRB   <= '1;
                        AXI_TXN_DONE  <= 1'b0;
                        AXI_ERROR     <= 1'b0;
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    burst_cnt <= '0;
                    wpat      <= PW'(1);
                    rpat      <= PW'(1);
                    if (check_fail) begin
                        AXI_ERROR    <= 1'b1;
                        AXI_TXN_DONE <= 1'b1;
                        state        <= DONE;
                    end else if (cfg_mode == 2'b01) begin
                        M_AXI_ARADDR  <= raddr;
                        M_AXI_ARVALID <= 1'b1;
                        state         <= RADDR;
                    end else begin
                        M_AXI_AWADDR  <= waddr;
                        M_AXI_AWVALID <= 1'b1;
                        state         <= WADDR;
                    end
                end
                WADDR: begin
                    if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b1;
                        M_AXI_WDATA   <= DW'(wpat);
                        M_AXI_WLAST   <= (cfg_len == 9'd1);
                        beat_cnt      <= '0;
                        state         <= WDATA;
                    end
                end
                WDATA: begin
                    if (M_AXI_WREADY) begin
                        wpat <= wpat + PW'(1);
                        if (last_beat) begin
                            M_AXI_WVALID <= 1'b0;
                            M_AXI_WLAST  <= 1'b0;
                            M_AXI_BREADY <= 1'b1;
                            state        <= WRESP;
                        end else begin
                            beat_cnt    <= beat_cnt + 9'd1;
                            M_AXI_WDATA <= DW'(wpat + PW'(1));
                            M_AXI_WLAST <= (beat_cnt + 9'd1 == cfg_len - 9'd1);
                        end
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP != 2'b00) AXI_ERROR <= 1'b1;
                        waddr <= waddr + AW'(burst_bytes);
                        if (burst_cnt == cfg_nb) begin
                            burst_cnt <= '0;
                            if (cfg_mode == 2'b10) begin
                                M_AXI_ARADDR  <= raddr;
                                M_AXI_ARVALID <= 1'b1;
                                state         <= RADDR;
                            end else begin
                                AXI_TXN_DONE <= 1'b1;
                                state        <= DONE;
                            end
                        end else begin
                            burst_cnt     <= burst_cnt + NB'(1);
                            M_AXI_AWADDR  <= waddr + AW'(burst_bytes);
                            M_AXI_AWVALID <= 1'b1;
                            state         <= WADDR;
                        end
                    end
                end
                RADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        beat_cnt      <= '0;
                        state         <= RDATA;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID) begin
                        rpat <= rpat + PW'(1);
                        if (M_AXI_RRESP != 2'b00) AXI_ERROR <= 1'b1;
                        if (cfg_mode == 2'b10 && M_AXI_RDATA != DW'(rpat)) AXI_ERROR <= 1'b1;
                        if (M_AXI_RLAST != last_beat) AXI_ERROR <= 1'b1;
                        if (last_beat) begin
                            M_AXI_RREADY <= 1'b0;
                            raddr        <= raddr + AW'(burst_bytes);
                            if (burst_cnt == cfg_nb) begin
                                burst_cnt    <= '0;
                                AXI_TXN_DONE <= 1'b1;
                                state        <= DONE;
                            end else begin
                                burst_cnt     <= burst_cnt + NB'(1);
                                M_AXI_ARADDR  <= raddr + AW'(burst_bytes);
                                M_AXI_ARVALID <= 1'b1;
                                state         <= RADDR;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_traffic_gen.sv
`default_nettype none
// ============================================================================
// tb_axi4_burst_traffic_gen - scoreboard bench with a memory-backed AXI slave
// for axi4_burst_traffic_gen. Rev 1.0
// ============================================================================
module tb_axi4_burst_traffic_gen;

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } ax_t;
    typedef struct packed { logic [31:0] data; logic last; } w_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic [31:0] cfg_waddr, cfg_raddr;
    logic [7:0]  cfg_nb;
    logic [8:0]  cfg_len;
    logic [1:0]  cfg_mode;
    logic        done, error;
    logic [0:0]  awid, arid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    ax_t  exp_aw[$];
    ax_t  exp_ar[$];
    w_t   exp_w[$];
    logic exp_done[$];
    logic [31:0] mem [logic [31:0]];

    int total = 0;
    int passed = 0;
    bit rand_bp = 1'b0;
    int bresp_err_burst = -1;
    int corrupt_burst = -1;
    int corrupt_beat = -1;
    int wr_burst = 0, rd_burst = 0;
    int wr_base = 0, rd_base = 0;

    always #5 clk = ~clk;

    axi4_burst_traffic_gen dut (
        .ACLK(clk), .ARESETN(rst_n), .INIT_AXI_TXN(init),
        .CFG_BASE_WADDR(cfg_waddr), .CFG_BASE_RADDR(cfg_raddr),
        .CFG_NUM_BURST(cfg_nb), .CFG_BURST_LEN(cfg_len), .CFG_MODE(cfg_mode),
        .AXI_TXN_DONE(done), .AXI_ERROR(error),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
        .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
        .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit coin();
        return !rand_bp || ($urandom_range(0, 1) == 1);
    endfunction

    // Slave write side: all slave-driven signals change on the falling edge.
    initial begin : slave_wr
        logic [31:0] wa;
        bit have_aw, b_pend, b_taken;
        wa = '0; have_aw = 0; b_pend = 0; b_taken = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; have_aw = 0; b_pend = 0; b_taken = 0;
            end else begin
                if (b_taken) begin bvalid = 0; b_taken = 0; end
                if (b_pend && !bvalid && coin()) begin
                    bvalid = 1;
                    bresp  = ((wr_burst - wr_base) == bresp_err_burst) ? 2'b10 : 2'b00;
                end
                if (bvalid && bready) begin b_pend = 0; b_taken = 1; wr_burst++; end
                wready = have_aw && coin();
                if (wvalid && wready) begin
                    mem[wa] = wdata;
                    wa = wa + 32'd4;
                    if (wlast) begin have_aw = 0; b_pend = 1; end
                end
                awready = !have_aw && !b_pend && coin();
                if (awvalid && awready) begin have_aw = 1; wa = awaddr; end
            end
        end
    end

    initial begin : slave_rd
        logic [31:0] ra;
        logic [7:0]  rlen_q;
        int rbeat;
        bit have_ar, r_taken;
        ra = '0; rlen_q = '0; rbeat = 0; have_ar = 0; r_taken = 0;
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 0; rvalid = 0; rlast = 0; have_ar = 0; r_taken = 0;
            end else begin
                if (r_taken) begin rvalid = 0; rlast = 0; r_taken = 0; end
                arready = !have_ar && coin();
                if (have_ar && !rvalid && coin()) begin
                    rvalid = 1;
                    rdata  = mem.exists(ra) ? mem[ra] : 32'hDEAD_BEEF;
                    if ((rd_burst - rd_base) == corrupt_burst && rbeat == corrupt_beat)
                        rdata = rdata ^ 32'h0000_0100;
                    rlast = (rbeat == int'(rlen_q));
                    rresp = 2'b00;
                end
                if (rvalid && rready) begin
                    r_taken = 1;
                    ra = ra + 32'd4;
                    if (rbeat == int'(rlen_q)) begin have_ar = 0; rd_burst++; end
                    rbeat++;
                end
                if (arvalid && arready) begin have_ar = 1; ra = araddr; rlen_q = arlen; rbeat = 0; end
            end
        end
    end

    // Monitor: compares every handshake and DONE edge against the scoreboard queues.
    initial begin : monitor
        bit aw_st, w_st, ar_st, done_q;
        logic [31:0] aw_a, w_d, ar_a;
        ax_t e;
        w_t  ew;
        aw_st = 0; w_st = 0; ar_st = 0; done_q = 0; aw_a = '0; w_d = '0; ar_a = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                aw_st = 0; w_st = 0; ar_st = 0; done_q = 0;
            end else begin
                if (aw_st) chk("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, aw_a}));
                if (w_st)  chk("w_hold",  64'({wvalid, wdata}),  64'({1'b1, w_d}));
                if (ar_st) chk("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, ar_a}));
                if (awvalid && awready) begin
                    chk("aw_expected", 64'(exp_aw.size() != 0), 64'(1));
                    if (exp_aw.size() != 0) begin
                        e = exp_aw.pop_front();
                        chk("aw", 64'({awaddr, awlen, awsize, awburst}),
                                  64'({e.addr, e.len, 3'd2, 2'b01}));
                    end
                end
                if (wvalid && wready) begin
                    chk("w_expected", 64'(exp_w.size() != 0), 64'(1));
                    if (exp_w.size() != 0) begin
                        ew = exp_w.pop_front();
                        chk("w", 64'({wdata, wlast, wstrb}), 64'({ew.data, ew.last, 4'hF}));
                    end
                end
                if (arvalid && arready) begin
                    chk("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
                    if (exp_ar.size() != 0) begin
                        e = exp_ar.pop_front();
                        chk("ar", 64'({araddr, arlen, arsize, arburst}),
                                  64'({e.addr, e.len, 3'd2, 2'b01}));
                    end
                end
                if (done && !done_q) begin
                    chk("done_expected", 64'(exp_done.size() != 0), 64'(1));
                    if (exp_done.size() != 0) chk("error_at_done", 64'(error), 64'(exp_done.pop_front()));
                end
                aw_st = awvalid && !awready; aw_a = awaddr;
                w_st  = wvalid && !wready;   w_d  = wdata;
                ar_st = arvalid && !arready; ar_a = araddr;
                done_q = done;
            end
        end
    end

    task automatic expect_run(input logic [1:0] mode, input logic [31:0] wb, input logic [31:0] rb,
                              input int nb, input int len, input bit bus, input bit exp_err);
        if (bus) begin
            for (int n = 0; n <= nb; n++) begin
                if (mode != 2'b01) begin
                    exp_aw.push_back({wb + 32'(n * len * 4), 8'(len - 1)});
                    for (int k = 0; k < len; k++)
                        exp_w.push_back({32'(n * len + k + 1), (k == len - 1)});
                end
                if (mode != 2'b00) exp_ar.push_back({rb + 32'(n * len * 4), 8'(len - 1)});
            end
        end
        exp_done.push_back(exp_err);
        wr_base = wr_burst;
        rd_base = rd_burst;
        cfg_mode = mode; cfg_waddr = wb; cfg_raddr = rb;
        cfg_nb = 8'(nb); cfg_len = 9'(len);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic finish_run(input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < 8000 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'(1));
        repeat (3) @(negedge clk);
        chk({name, "_queues_drained"},
            64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_done.size()), 64'(0));
    endtask

    task automatic run(input string name, input logic [1:0] mode, input logic [31:0] wb,
                       input logic [31:0] rb, input int nb, input int len,
                       input bit bus, input bit exp_err);
        expect_run(mode, wb, rb, nb, len, bus, exp_err);
        finish_run(name);
    endtask

    initial begin : main
        bit seen;
        rst_n = 1'b0; init = 1'b0;
        cfg_waddr = '0; cfg_raddr = '0; cfg_nb = '0; cfg_len = '0; cfg_mode = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'(0));
        chk("reset_status", 64'({done, error}), 64'(0));
        chk("reset_addr",   64'({awaddr, araddr}), 64'(0));
        chk("reset_wdata",  64'({wdata, wlast, awlen}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run("single_write",   2'b00, 32'h8000_0000, 32'h8000_0000, 0, 1, 1, 0);
        run("write_compare",  2'b10, 32'h8000_0000, 32'h8000_0000, 3, 16, 1, 0);
        corrupt_burst = 2; corrupt_beat = 5;
        run("corrupt_read",   2'b10, 32'h8000_0000, 32'h8000_0000, 3, 16, 1, 1);
        corrupt_burst = -1; corrupt_beat = -1;
        run("cross_4k",       2'b00, 32'h8000_0F00, 32'h8000_0000, 0, 256, 0, 1);
        run("cross_4k_late",  2'b00, 32'h8000_4E80, 32'h8000_0000, 1, 64, 0, 1);
        run("touch_4k_edge",  2'b00, 32'h8000_4E00, 32'h8000_0000, 2, 64, 1, 0);
        run("mode_illegal",   2'b11, 32'h8000_0000, 32'h8000_0000, 0, 4, 0, 1);
        run("len_zero",       2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 1);
        run("len_max",        2'b10, 32'h8000_3000, 32'h8000_3000, 0, 256, 1, 0);

        rand_bp = 1'b1; bresp_err_burst = 0;
        run("bresp_slverr",   2'b10, 32'h8000_1000, 32'h8000_1000, 1, 4, 1, 1);
        bresp_err_burst = -1;
        run("read_only",      2'b01, 32'h8000_0000, 32'h8000_0000, 1, 8, 1, 0);
        rand_bp = 1'b0;

        // Abandon a write run mid-burst with an asynchronous reset.
        expect_run(2'b00, 32'h8000_2000, 32'h8000_2000, 1, 8, 1, 0);
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = wvalid;
        end
        chk("abort_reached_wdata", 64'(seen), 64'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", 64'({awvalid, wvalid, wlast, bready, arvalid, rready, done, error}), 64'(0));
        chk("abort_wdata_zero", 64'(wdata), 64'(0));
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_done.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'({done, error, wvalid}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run("rerun_after_rst", 2'b00, 32'h8000_2000, 32'h8000_2000, 1, 8, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
